// File: rtl/conv1d_pkg.sv
// rtl/conv1d_pkg.sv - shared types and constants for the conv1d input dispatch
// Purpose: dispatcher FSM state encoding, branch count and a one-hot helper.
// Ports: none (package).
package conv1d_pkg;

  localparam int N_BRANCH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } dispatch_state_t;

  // One-hot branch select for a 2-bit round-robin pointer.
  function automatic logic [N_BRANCH-1:0] onehot_branch(input logic [1:0] ptr);
    logic [N_BRANCH-1:0] one;
    one = {{(N_BRANCH-1){1'b0}}, 1'b1};
    return one << ptr;
  endfunction

endpackage

// File: rtl/dispatch_out_reg.sv
// rtl/dispatch_out_reg.sv - one-entry output holding register with valid/last flags
// Purpose: holds the sample currently offered to a branch until its handshake.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   load            capture load_data/load_valid/load_last (has priority over clear)
//   load_data       sample to hold
//   load_valid      one-hot branch valid for the loaded sample
//   load_last       final-sample flag for the loaded sample
//   clear           drop valid/last after a handshake with no replacement sample
//   data, valid, last  registered outputs
module dispatch_out_reg
  import conv1d_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [WIDTH-1:0]    load_data,
  input  logic [N_BRANCH-1:0] load_valid,
  input  logic                load_last,
  input  logic                clear,
  output logic [WIDTH-1:0]    data,
  output logic [N_BRANCH-1:0] valid,
  output logic                last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= '0;
      last  <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      valid <= load_valid;
      last  <= load_last;
    end else if (clear) begin
      // data is left as-is; it is only meaningful while valid is set
      valid <= '0;
      last  <= 1'b0;
    end
  end

endmodule

// File: rtl/conv1d_dispatch.sv
// rtl/conv1d_dispatch.sv - round-robin scatter of a sample frame to four conv branches
// Purpose: accepts LEN samples over valid/ready and deals sample i to branch i mod 4.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start, len      frame start pulse and sample count (sampled in IDLE only)
//   busy, done      frame in progress / one-cycle completion pulse
//   in_valid, in_ready, in_data     upstream sample stream
//   out_valid (one-hot), out_ready, out_data, out_last   branch-side stream
module conv1d_dispatch
  import conv1d_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LEN_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [LEN_W-1:0]    len,
  output logic                busy,
  output logic                done,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_data,
  output logic [N_BRANCH-1:0] out_valid,
  input  logic [N_BRANCH-1:0] out_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_last
);

  dispatch_state_t state, state_next;

  logic [1:0]       ptr;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len_q;
  logic             done_q;

  logic             hs;
  logic             is_last;
  logic             accept;
  logic             clear;
  logic             start_frame;
  logic             done_next;
  logic             ready_c;

  // Only the addressed branch's ready matters since out_valid is one-hot.
  assign hs      = |(out_valid & out_ready);
  assign is_last = (cnt == (len_q - LEN_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    ready_c     = 1'b0;
    accept      = 1'b0;
    clear       = 1'b0;
    start_frame = 1'b0;
    done_next   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            start_frame = 1'b1;
            state_next  = RUN;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      RUN: begin
        // Register is free if empty or being drained this cycle.
        ready_c = !(|out_valid) || hs;
        accept  = in_valid && ready_c;
        clear   = hs && !accept;
        if (accept && is_last) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        clear = hs;
        if (hs) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr    <= 2'd0;
      cnt    <= '0;
      len_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= done_next;
      if (start_frame) begin
        // Every frame restarts at branch 0.
        len_q <= len;
        ptr   <= 2'd0;
        cnt   <= '0;
      end else if (accept) begin
        ptr <= ptr + 2'd1;
        cnt <= cnt + LEN_W'(1);
      end
    end
  end

  dispatch_out_reg #(
    .WIDTH(WIDTH)
  ) u_out_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (accept),
    .load_data  (in_data),
    .load_valid (onehot_branch(ptr)),
    .load_last  (is_last),
    .clear      (clear),
    .data       (out_data),
    .valid      (out_valid),
    .last       (out_last)
  );

  assign busy     = (state != IDLE);
  assign done     = done_q;
  assign in_ready = ready_c;

endmodule

// File: tb/tb_conv1d_dispatch.sv
// tb/tb_conv1d_dispatch.sv - directed self-checking bench for conv1d_dispatch
module tb_conv1d_dispatch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] len = '0;
  logic        busy;
  logic        done;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = 4'hF;
  logic [31:0] out_data;
  logic        out_last;

  int vectors = 0;
  int miscompares = 0;

  conv1d_dispatch #(.WIDTH(32), .LEN_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 4'hF;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      start     = 1'($urandom);
      len       = 16'($urandom);
      in_valid  = 1'($urandom);
      in_data   = $urandom;
      out_ready = 4'($urandom);
      #1;
      vectors++;
      if ({busy, done, in_ready, out_valid, out_last} !== 8'h00) begin
        miscompares++;
        $display("FAIL reset c%0d: busy=%b done=%b in_ready=%b out_valid=%b out_last=%b, required all 0",
                 c, busy, done, in_ready, out_valid, out_last);
      end
    end
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [3:0] exp_v;
    @(negedge clk);
    start = 1'b1; len = 16'd6;
    #1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL basic_busy_pre: got %b required 0", busy);
    end
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      start = 1'b0;
      in_valid = (c < 6);
      in_data  = 32'h10 + 32'(c);
      #1;
      vectors++;
      if (busy !== 1'b1) begin
        miscompares++; $display("FAIL basic_busy c%0d: got %b required 1", c, busy);
      end
      if (c < 6) begin
        vectors++;
        if (in_ready !== 1'b1) begin
          miscompares++; $display("FAIL basic_in_ready c%0d: got %b required 1", c, in_ready);
        end
      end
      if (c >= 1) begin
        exp_v = 4'b0001 << ((c - 1) % 4);
        vectors++;
        if (out_valid !== exp_v || out_data !== 32'h10 + 32'(c - 1) || out_last !== (c == 6)) begin
          miscompares++;
          $display("FAIL basic_out c%0d: valid=%b data=%h last=%b required valid=%b data=%h last=%b",
                   c, out_valid, out_data, out_last, exp_v, 32'h10 + 32'(c - 1), (c == 6));
        end
      end
    end
    @(negedge clk);
    #1;
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 4'b0000) begin
      miscompares++;
      $display("FAIL basic_done: done=%b busy=%b out_valid=%b required 1 0 0000", done, busy, out_valid);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (done !== 1'b0) begin
      miscompares++; $display("FAIL basic_done_width: got %b required 0", done);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    start = 1'b1; len = 16'd6;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 32'h10;
    @(negedge clk);
    in_data = 32'h11;
    @(negedge clk);
    in_data = 32'h12;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_data = 32'h13; out_ready = 4'b1011;
      #1;
      vectors++;
      if (in_ready !== 1'b0 || out_data !== 32'h12 || out_valid !== 4'b0100) begin
        miscompares++;
        $display("FAIL bp_hold c%0d: in_ready=%b data=%h valid=%b required 0 00000012 0100",
                 c, in_ready, out_data, out_valid);
      end
    end
    @(negedge clk);
    out_ready = 4'hF;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_data !== 32'h12) begin
      miscompares++;
      $display("FAIL bp_release: in_ready=%b data=%h required 1 00000012", in_ready, out_data);
    end
    @(negedge clk);
    in_data = 32'h14;
    #1;
    vectors++;
    if (out_valid !== 4'b1000 || out_data !== 32'h13) begin
      miscompares++;
      $display("FAIL bp_resume: valid=%b data=%h required 1000 00000013", out_valid, out_data);
    end
    @(negedge clk);
    in_data = 32'h15;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 4'b0010 || out_data !== 32'h15 || out_last !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_last: valid=%b data=%h last=%b required 0010 00000015 1",
               out_valid, out_data, out_last);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (done !== 1'b1) begin
      miscompares++; $display("FAIL bp_done: got %b required 1", done);
    end
  endtask

  task automatic test_zero_len();
    @(negedge clk);
    idle_inputs();
    start = 1'b1; len = 16'd0;
    @(negedge clk);
    start = 1'b0;
    #1;
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 4'b0000) begin
      miscompares++;
      $display("FAIL zero_done: done=%b busy=%b valid=%b required 1 0 0000", done, busy, out_valid);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 4'b0000) begin
      miscompares++;
      $display("FAIL zero_after: done=%b busy=%b valid=%b required 0 0 0000", done, busy, out_valid);
    end
  endtask

  task automatic test_start_while_busy();
    int hs_cnt = 0;
    int done_cnt = 0;
    int last_cnt = 0;
    @(negedge clk);
    idle_inputs();
    start = 1'b1; len = 16'd5;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      start    = (c == 2);
      len      = (c >= 2) ? 16'd2 : 16'd5;
      in_valid = 1'b1;
      in_data  = 32'h40 + 32'(c);
      #1;
      hs_cnt   += $countones(out_valid & out_ready);
      done_cnt += int'(done);
      last_cnt += int'(out_last && (out_valid != 4'b0000));
    end
    idle_inputs();
    vectors++;
    if (hs_cnt != 5) begin
      miscompares++; $display("FAIL swb_samples: got %0d required 5", hs_cnt);
    end
    vectors++;
    if (done_cnt != 1) begin
      miscompares++; $display("FAIL swb_done_count: got %0d required 1", done_cnt);
    end
    vectors++;
    if (last_cnt != 1 || busy !== 1'b0) begin
      miscompares++; $display("FAIL swb_last_busy: last=%0d busy=%b required 1 0", last_cnt, busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    int done_cnt = 0;
    @(negedge clk);
    idle_inputs();
    start = 1'b1; len = 16'd8;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; in_data = 32'h80 + 32'(c);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, in_ready, out_valid, out_last} !== 8'h00) begin
      miscompares++;
      $display("FAIL rmf_reset: busy=%b done=%b in_ready=%b valid=%b last=%b required all 0",
               busy, done, in_ready, out_valid, out_last);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      done_cnt += int'(done);
    end
    idle_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    done_cnt += int'(done);
    vectors++;
    if (done_cnt != 0) begin
      miscompares++; $display("FAIL rmf_no_done: got %0d required 0", done_cnt);
    end
    start = 1'b1; len = 16'd1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 32'hAB;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL rmf_ready: got %b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 4'b0001 || out_last !== 1'b1 || out_data !== 32'hAB) begin
      miscompares++;
      $display("FAIL rmf_single: valid=%b last=%b data=%h required 0001 1 000000ab",
               out_valid, out_last, out_data);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      miscompares++; $display("FAIL rmf_done: done=%b busy=%b required 1 0", done, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_len();
    test_start_while_busy();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/conv1d_dispatch.md
# conv1d_dispatch

Input-side scatter unit of the conv1d accelerator. It accepts one frame of LEN samples over a valid/ready stream and deals them round-robin to the four convolution branches: sample i goes to branch i mod 4. It is the counterpart of the output-side gather that muxes and accumulates the four branch results. Frame control is a start pulse plus a length, and completion is signalled by a one-cycle done pulse.

## Interface
- WIDTH, 32, sample width in bits
- LEN_W, 16, width of the frame-length field
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  frame start pulse; sampled only in IDLE
- len  in  LEN_W  number of samples in the frame; sampled together with start
- busy  out  1  high from the cycle after an accepted start until the cycle done is asserted
- done  out  1  one-cycle pulse marking frame completion
- in_valid  in  1  upstream sample valid
- in_ready  out  1  upstream sample ready
- in_data  in  WIDTH  upstream sample
- out_valid  out  4  one-hot valid, one bit per branch
- out_ready  in  4  per-branch ready
- out_data  out  WIDTH  sample bus shared by all branches
- out_last  out  1  marks the final sample of the frame; qualified by out_valid

## Operation
- **Reset values.** All outputs are 0. FSM is IDLE; branch pointer, sample counter and output register are cleared.
- **FSM states:** IDLE, RUN, FLUSH.
- **IDLE.**
  - start with len != 0: latch len, set ptr = 0 and cnt = 0, go to RUN.
  - start with len == 0: pulse done in the next cycle and stay in IDLE.
- **RUN.**
  - in_ready = !(|out_valid) || (|(out_valid & out_ready)).
  - Accept condition: in_valid && in_ready.
  - On accept: load in_data into the output register and set out_valid = onehot(ptr). Set out_last = (cnt == len-1). Then ptr = ptr+1 mod 4 and cnt++.
  - The accept that carries the last sample moves the FSM to FLUSH.
- **FLUSH.**
  - in_ready = 0.
  - When the held sample completes its handshake (out_valid[k] && out_ready[k]), clear out_valid and out_last, pulse done, and go to IDLE.
- **Output hold rules.**
  - The output register holds one sample.
  - While out_valid[k]=1 and out_ready[k]=0, out_data, out_valid and out_last stay stable.
  - out_ready bits of branches not currently addressed are ignored.
- **Branch 0 convention.** Every frame starts at branch 0, regardless of where the previous frame ended.
- start outside IDLE is ignored, and len is not re-sampled.
- **Arithmetic.** cnt is LEN_W bits with no wrap: the maximum len is 2^LEN_W-1. ptr is 2 bits and wraps 3→0.
- **Reset mid-frame.** Aborts immediately to reset values, with no done pulse. Partially dealt samples are lost.

## Timing
- A sample accepted at edge t is visible on out_data/out_valid after edge t. Latency is one cycle.
- Sustained throughput is 1 sample/cycle while the addressed branch's out_ready stays high.
- in_ready depends combinationally on out_ready. in_data has no combinational path to any output.
- Done timing:
  - done asserts for exactly one cycle, in the cycle after the last out_* handshake.
  - For len == 0, done asserts in the cycle after start.
- busy deasserts in the same cycle done asserts. A new start is accepted in that same cycle (FSM is in IDLE).

## Structure
- Shared package conv1d_pkg holds:
  - the dispatch_state_t enum (IDLE, RUN, FLUSH);
  - localparam N_BRANCH = 4.
- One sub-module, dispatch_out_reg, implements the one-entry output holding register with the valid/last flags and async active-low reset.
- FSM, pointer and counter live in the top module.

## Test plan
- **Reset.** Hold rst_n=0 with random inputs. Expected: busy, done, in_ready, out_valid and out_last are all 0.
- **Basic frame, no backpressure.** len=6, in_data 0x10..0x15 back-to-back, out_ready=4'hF. Expected:
  - branch0 receives 0x10 and 0x14, branch1 receives 0x11 and 0x15, branch2 receives 0x12, branch3 receives 0x13;
  - out_last is high only with 0x15 on out_valid=4'b0010;
  - done pulses 1 cycle after that handshake;
  - 6 samples complete in 6 consecutive cycles.
- **Backpressure.** Hold out_ready[2]=0 for 5 cycles while sample 0x12 is pending. Expected: in_ready=0 and out_data=0x12 stable for all 5 cycles; the stream resumes with 0x13 on branch3.
- **Zero length.** start with len=0. Expected: done for exactly 1 cycle on the next cycle, out_valid never set, busy stays 0.
- **Start while busy.** Assert start with len=2 during a len=5 frame. Expected: ignored; exactly 5 samples are dealt and one done pulse occurs.
- **Reset mid-frame.** Drop rst_n after 3 accepted samples of a len=8 frame. Expected: outputs return to 0 with no done pulse. A following len=1 frame delivers its sample on out_valid=4'b0001 with out_last=1.
